// File: rtl/trap_controller_pkg.sv
// Shared trap/CSR encodings: FSM states, cause codes, funct3 codes and the
// small decode helpers used by the trap controller and the CSR file.
package trap_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRAP_SAVE = 3'd1,
    ST_TRAP_JUMP = 3'd2,
    ST_RET_JUMP  = 3'd3,
    ST_CSR_WR    = 3'd4
  } state_e;

  localparam logic [3:0] CAUSE_MIS_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK    = 4'd3;
  localparam logic [3:0] CAUSE_MIS_LOAD  = 4'd4;
  localparam logic [3:0] CAUSE_MIS_STORE = 4'd6;
  localparam logic [3:0] CAUSE_ECALL     = 4'd8;
  localparam logic [3:0] CAUSE_CSR_WRITE = 4'd15;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Highest-priority exception wins when several flags arrive together.
  function automatic logic [3:0] select_cause(
    input logic mis_fetch,
    input logic illegal,
    input logic ebreak,
    input logic ecall,
    input logic mis_store,
    input logic mis_load
  );
    logic [3:0] cause;
    if (mis_fetch) begin
      cause = CAUSE_MIS_FETCH;
    end else if (illegal) begin
      cause = CAUSE_ILLEGAL;
    end else if (ebreak) begin
      cause = CAUSE_EBREAK;
    end else if (ecall) begin
      cause = CAUSE_ECALL;
    end else if (mis_store) begin
      cause = CAUSE_MIS_STORE;
    end else if (mis_load) begin
      cause = CAUSE_MIS_LOAD;
    end else begin
      cause = CAUSE_MIS_FETCH;
    end
    return cause;
  endfunction

  // Set/clear forms with a zero rs1/zimm field must not write the CSR.
  function automatic logic csr_write_suppressed(
    input logic [2:0] funct3,
    input logic [4:0] rs1_field
  );
    logic set_clear;
    case (funct3)
      F3_CSRRS, F3_CSRRC, F3_CSRRSI, F3_CSRRCI: set_clear = 1'b1;
      default:                                  set_clear = 1'b0;
    endcase
    return set_clear && (rs1_field == 5'd0);
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Decode-side request bus and CSR-file/pipeline response bus of the trap
// controller; the controller uses the slave view.
interface trap_controller_if #(
  parameter int XLEN = 32
);

  logic            iValid;
  logic [XLEN-1:0] iPC;
  logic [XLEN-1:0] iInstr;
  logic            iMisFetch;
  logic            iIllegal;
  logic            iEcall;
  logic            iEbreak;
  logic            iMisLoad;
  logic            iMisStore;
  logic            iUret;
  logic            iCsrOp;
  logic [XLEN-1:0] iRs1Val;
  logic [XLEN-1:0] iCSROld;
  logic [XLEN-1:0] iUTVEC;
  logic [XLEN-1:0] iUEPC;

  logic            oCSRWrite;
  logic [XLEN-1:0] oUcause;
  logic [XLEN-1:0] oPC;
  logic [XLEN-1:0] oInstr;
  logic [XLEN-1:0] oWriteData;
  logic            oRedirect;
  logic [XLEN-1:0] oTargetPC;
  logic            oStall;
  logic            oFlush;
  logic [XLEN-1:0] oTrapCount;

  modport master (
    output iValid, iPC, iInstr, iMisFetch, iIllegal, iEcall, iEbreak,
           iMisLoad, iMisStore, iUret, iCsrOp, iRs1Val, iCSROld, iUTVEC, iUEPC,
    input  oCSRWrite, oUcause, oPC, oInstr, oWriteData, oRedirect,
           oTargetPC, oStall, oFlush, oTrapCount
  );

  modport slave (
    input  iValid, iPC, iInstr, iMisFetch, iIllegal, iEcall, iEbreak,
           iMisLoad, iMisStore, iUret, iCsrOp, iRs1Val, iCSROld, iUTVEC, iUEPC,
    output oCSRWrite, oUcause, oPC, oInstr, oWriteData, oRedirect,
           oTargetPC, oStall, oFlush, oTrapCount
  );

endinterface

// File: rtl/trap_controller_csr_alu.sv
// Combinational CSR write-data calculation (csr_alu): write, set or clear
// using either rs1 or the zero-extended 5-bit immediate.
module trap_controller_csr_alu
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      zimm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] old_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] operand_s;

  // funct3[2] selects the immediate forms; funct3[1:0] picks the operation.
  always_comb begin
    operand_s = rs1_i;
    result_o  = {XLEN{1'b0}};
    if (funct3_i[2]) begin
      operand_s = {{(XLEN-5){1'b0}}, zimm_i};
    end else begin
      operand_s = rs1_i;
    end
    case (funct3_i[1:0])
      2'b01:   result_o = operand_s;
      2'b10:   result_o = old_i | operand_s;
      2'b11:   result_o = old_i & ~operand_s;
      default: result_o = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/trap_controller.sv
// Trap/uret/CSR-instruction sequencer: captures a decode-stage event, drives
// the CSR-file write and the PC redirect, and stalls decode while busy.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  trap_controller_if.slave bus
);

  state_e          state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] instr_d, instr_q;
  logic [XLEN-1:0] rs1_d, rs1_q;
  logic [XLEN-1:0] old_d, old_q;
  logic [2:0]      funct3_d, funct3_q;

  logic            accept_s;
  logic            exc_s;
  logic [3:0]      cause_s;
  logic            suppress_s;
  logic [XLEN-1:0] alu_result_s;

  logic            csr_write_q;
  logic [XLEN-1:0] ucause_q;
  logic [XLEN-1:0] wdata_q;
  logic            redirect_q;
  logic [XLEN-1:0] target_q;
  logic            stall_q;
  logic            flush_q;
  logic [XLEN-1:0] trap_count_q;

  // Capture-register next values and event decode at the accept edge.
  always_comb begin
    accept_s = (state_q == ST_IDLE) && bus.iValid;
    exc_s    = bus.iMisFetch | bus.iIllegal | bus.iEcall |
               bus.iEbreak | bus.iMisLoad | bus.iMisStore;
    cause_s  = select_cause(bus.iMisFetch, bus.iIllegal, bus.iEbreak,
                            bus.iEcall, bus.iMisStore, bus.iMisLoad);
    if (accept_s) begin
      pc_d     = bus.iPC;
      instr_d  = bus.iInstr;
      rs1_d    = bus.iRs1Val;
      old_d    = bus.iCSROld;
      funct3_d = bus.iInstr[14:12];
    end else begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      rs1_d    = rs1_q;
      old_d    = old_q;
      funct3_d = funct3_q;
    end
    suppress_s = csr_write_suppressed(funct3_d, instr_d[19:15]);
  end

  // Fed from the next-capture values so the write data is registered in
  // step with the CSR_WR state.
  trap_controller_csr_alu #(
    .XLEN (XLEN)
  ) u_csr_alu (
    .funct3_i (funct3_d),
    .zimm_i   (instr_d[19:15]),
    .rs1_i    (rs1_d),
    .old_i    (old_d),
    .result_o (alu_result_s)
  );

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      pc_q         <= {XLEN{1'b0}};
      instr_q      <= {XLEN{1'b0}};
      rs1_q        <= {XLEN{1'b0}};
      old_q        <= {XLEN{1'b0}};
      funct3_q     <= 3'b000;
      csr_write_q  <= 1'b0;
      ucause_q     <= {XLEN{1'b0}};
      wdata_q      <= {XLEN{1'b0}};
      redirect_q   <= 1'b0;
      target_q     <= {XLEN{1'b0}};
      stall_q      <= 1'b0;
      flush_q      <= 1'b0;
      trap_count_q <= {XLEN{1'b0}};
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      rs1_q       <= rs1_d;
      old_q       <= old_d;
      funct3_q    <= funct3_d;
      csr_write_q <= 1'b0;
      ucause_q    <= {XLEN{1'b0}};
      wdata_q     <= {XLEN{1'b0}};
      redirect_q  <= 1'b0;
      target_q    <= {XLEN{1'b0}};
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s && exc_s) begin
            state_q     <= ST_TRAP_SAVE;
            csr_write_q <= 1'b1;
            ucause_q    <= {{(XLEN-4){1'b0}}, cause_s};
            stall_q     <= 1'b1;
          end else if (accept_s && bus.iUret) begin
            state_q    <= ST_RET_JUMP;
            redirect_q <= 1'b1;
            flush_q    <= 1'b1;
            target_q   <= bus.iUEPC;
            stall_q    <= 1'b1;
          end else if (accept_s && bus.iCsrOp) begin
            state_q     <= ST_CSR_WR;
            csr_write_q <= ~suppress_s;
            ucause_q    <= {{(XLEN-4){1'b0}}, CAUSE_CSR_WRITE};
            wdata_q     <= alu_result_s;
            stall_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_TRAP_SAVE: begin
          state_q      <= ST_TRAP_JUMP;
          redirect_q   <= 1'b1;
          flush_q      <= 1'b1;
          target_q     <= bus.iUTVEC & {{(XLEN-2){1'b1}}, 2'b00};
          stall_q      <= 1'b1;
          trap_count_q <= trap_count_q + {{(XLEN-1){1'b0}}, 1'b1};
        end
        ST_TRAP_JUMP: state_q <= ST_IDLE;
        ST_RET_JUMP:  state_q <= ST_IDLE;
        ST_CSR_WR:    state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.oCSRWrite  = csr_write_q;
  assign bus.oUcause    = ucause_q;
  assign bus.oPC        = pc_q;
  assign bus.oInstr     = instr_q;
  assign bus.oWriteData = wdata_q;
  assign bus.oRedirect  = redirect_q;
  assign bus.oTargetPC  = target_q;
  assign bus.oStall     = stall_q;
  assign bus.oFlush     = flush_q;
  assign bus.oTrapCount = trap_count_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed and randomized bench for trap_controller, checked cycle by cycle
// against a queue-based model of the expected output sequence per event.
module tb_trap_controller;

  logic iCLK;
  logic iRST;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic        csr_write;
    logic [31:0] ucause;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic        redirect;
    logic [31:0] target;
    logic        stall;
    logic        flush;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_cnt;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          n_assert;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t idle_rec();
    exp_t r;
    r.csr_write = 1'b0; r.ucause = 32'd0; r.pc = m_pc; r.instr = m_instr;
    r.wdata = 32'd0; r.redirect = 1'b0; r.target = 32'd0; r.stall = 1'b0;
    r.flush = 1'b0; r.count = m_cnt;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 32'd0; m_pc = 32'd0; m_instr = 32'd0;
  endtask

  function automatic logic [31:0] model_cause();
    if (bus.iMisFetch) return 32'd0;
    if (bus.iIllegal)  return 32'd2;
    if (bus.iEbreak)   return 32'd3;
    if (bus.iEcall)    return 32'd8;
    if (bus.iMisStore) return 32'd6;
    return 32'd4;
  endfunction

  function automatic logic [31:0] model_wdata();
    logic [2:0]  f3;
    logic [31:0] src;
    logic [31:0] ins;
    ins = bus.iInstr;
    f3  = ins[14:12];
    src = (f3 >= 3'd5) ? {27'd0, ins[19:15]} : bus.iRs1Val;
    case (f3)
      3'd1, 3'd5: return src;
      3'd2, 3'd6: return bus.iCSROld | src;
      3'd3, 3'd7: return bus.iCSROld & ~src;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic model_writes();
    logic [2:0]  f3;
    logic [31:0] ins;
    ins = bus.iInstr;
    f3  = ins[14:12];
    if ((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) && ins[19:15] == 5'd0)
      return 1'b0;
    return 1'b1;
  endfunction

  // Queue the per-cycle outputs the event accepted at the coming edge must produce.
  task automatic model_accept();
    exp_t r;
    m_pc    = bus.iPC;
    m_instr = bus.iInstr;
    if (bus.iMisFetch | bus.iIllegal | bus.iEcall | bus.iEbreak | bus.iMisLoad | bus.iMisStore) begin
      r = idle_rec(); r.csr_write = 1'b1; r.ucause = model_cause(); r.stall = 1'b1;
      exp_q.push_back(r);
      r = idle_rec(); r.redirect = 1'b1; r.flush = 1'b1; r.stall = 1'b1;
      r.target = bus.iUTVEC & ~32'd3; r.count = m_cnt + 32'd1;
      exp_q.push_back(r);
      m_cnt = m_cnt + 32'd1;
    end else if (bus.iUret) begin
      r = idle_rec(); r.redirect = 1'b1; r.flush = 1'b1; r.stall = 1'b1; r.target = bus.iUEPC;
      exp_q.push_back(r);
    end else if (bus.iCsrOp) begin
      r = idle_rec(); r.csr_write = model_writes(); r.ucause = 32'h0000000F;
      r.wdata = model_wdata(); r.stall = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic check_outputs(input exp_t r);
    chk("oCSRWrite",  {31'd0, bus.oCSRWrite}, {31'd0, r.csr_write});
    chk("oUcause",    bus.oUcause,    r.ucause);
    chk("oPC",        bus.oPC,        r.pc);
    chk("oInstr",     bus.oInstr,     r.instr);
    chk("oWriteData", bus.oWriteData, r.wdata);
    chk("oRedirect",  {31'd0, bus.oRedirect}, {31'd0, r.redirect});
    chk("oTargetPC",  bus.oTargetPC,  r.target);
    chk("oStall",     {31'd0, bus.oStall}, {31'd0, r.stall});
    chk("oFlush",     {31'd0, bus.oFlush}, {31'd0, r.flush});
    chk("oTrapCount", bus.oTrapCount, r.count);
  endtask

  // Called at a falling edge with inputs already driven: check, model, advance.
  task automatic tick();
    exp_t r;
    logic idle;
    idle = (exp_q.size() == 0);
    if (idle) r = idle_rec();
    else      r = exp_q.pop_front();
    check_outputs(r);
    if (idle && bus.iValid) model_accept();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic drive_clear();
    bus.iValid = 1'b0; bus.iPC = 32'd0; bus.iInstr = 32'd0;
    bus.iMisFetch = 1'b0; bus.iIllegal = 1'b0; bus.iEcall = 1'b0; bus.iEbreak = 1'b0;
    bus.iMisLoad = 1'b0; bus.iMisStore = 1'b0; bus.iUret = 1'b0; bus.iCsrOp = 1'b0;
    bus.iRs1Val = 32'd0; bus.iCSROld = 32'd0;
  endtask

  logic [2:0]  f3_tab [7];
  logic [31:0] instr_v;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    f3_tab = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0};
    iRST = 1'b1;
    drive_clear();
    bus.iUTVEC = 32'h80000103;
    bus.iUEPC  = 32'd0;
    model_reset();
    repeat (3) @(negedge iCLK);
    check_outputs(idle_rec());
    iRST = 1'b0;

    // Illegal instruction trap.
    bus.iValid = 1'b1; bus.iIllegal = 1'b1; bus.iPC = 32'h00400010; bus.iInstr = 32'hFFFFFFFF;
    tick();
    drive_clear();
    chk("ill_ucause", bus.oUcause, 32'd2);
    chk("ill_pc", bus.oPC, 32'h00400010);
    tick();
    chk("ill_target", bus.oTargetPC, 32'h80000100);
    tick();
    chk("ill_count", bus.oTrapCount, 32'd1);

    // Priority: misaligned fetch beats ecall; ecall beats uret.
    bus.iValid = 1'b1; bus.iMisFetch = 1'b1; bus.iEcall = 1'b1;
    tick();
    drive_clear();
    chk("prio_fetch", bus.oUcause, 32'd0);
    tick(); tick();
    bus.iValid = 1'b1; bus.iEcall = 1'b1; bus.iUret = 1'b1; bus.iUEPC = 32'h00000444;
    tick();
    drive_clear();
    chk("prio_ecall", bus.oUcause, 32'd8);
    tick(); tick();

    // csrrs with a non-zero rs1 field, then with rs1 field zero.
    bus.iValid = 1'b1; bus.iCsrOp = 1'b1; bus.iCSROld = 32'h0000F0F0; bus.iRs1Val = 32'h0000000F;
    bus.iInstr = {12'h305, 5'd5, 3'b010, 5'd1, 7'h73};
    tick();
    drive_clear();
    chk("csrrs_wdata", bus.oWriteData, 32'h0000F0FF);
    chk("csrrs_ucause", bus.oUcause, 32'h0000000F);
    tick();
    bus.iValid = 1'b1; bus.iCsrOp = 1'b1; bus.iCSROld = 32'h0000F0F0; bus.iRs1Val = 32'h0000000F;
    bus.iInstr = {12'h305, 5'd0, 3'b010, 5'd1, 7'h73};
    tick();
    drive_clear();
    chk("csrrs_x0_wr", {31'd0, bus.oCSRWrite}, 32'd0);
    tick();

    // csrrci with zimm=3.
    bus.iValid = 1'b1; bus.iCsrOp = 1'b1; bus.iCSROld = 32'h0000001F;
    bus.iInstr = {12'h305, 5'd3, 3'b111, 5'd1, 7'h73};
    tick();
    drive_clear();
    chk("csrrci_wdata", bus.oWriteData, 32'h0000001C);
    tick();

    // uret; an exception presented while busy must be ignored.
    bus.iValid = 1'b1; bus.iUret = 1'b1; bus.iUEPC = 32'h00400020;
    tick();
    chk("uret_target", bus.oTargetPC, 32'h00400020);
    bus.iUret = 1'b0; bus.iIllegal = 1'b1;
    tick();
    drive_clear();
    tick();

    // Reset while in TRAP_SAVE, with a new event pending on the inputs.
    bus.iValid = 1'b1; bus.iEcall = 1'b1; bus.iPC = 32'h00400100;
    tick();
    chk("rst_pre_stall", {31'd0, bus.oStall}, 32'd1);
    bus.iIllegal = 1'b1;
    iRST = 1'b1;
    #1;
    model_reset();
    check_outputs(idle_rec());
    chk("rst_count", bus.oTrapCount, 32'd0);
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    drive_clear();
    tick();

    // Randomized traffic, including events presented while stalled.
    for (int c = 0; c < 600; c++) begin
      bus.iValid    = ($urandom_range(0, 9) < 7);
      bus.iMisFetch = ($urandom_range(0, 15) == 0);
      bus.iIllegal  = ($urandom_range(0, 15) == 0);
      bus.iEcall    = ($urandom_range(0, 15) == 0);
      bus.iEbreak   = ($urandom_range(0, 15) == 0);
      bus.iMisLoad  = ($urandom_range(0, 15) == 0);
      bus.iMisStore = ($urandom_range(0, 15) == 0);
      bus.iUret     = ($urandom_range(0, 3) == 0);
      bus.iCsrOp    = ($urandom_range(0, 1) == 1);
      instr_v = $urandom;
      instr_v[14:12] = f3_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) instr_v[19:15] = 5'd0;
      bus.iInstr  = instr_v;
      bus.iPC     = $urandom;
      bus.iRs1Val = $urandom;
      bus.iCSROld = $urandom;
      if (exp_q.size() == 0) begin
        bus.iUTVEC = $urandom;
        bus.iUEPC  = $urandom;
      end
      tick();
    end

    drive_clear();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and CSR width.
REQ-002 SHALL have iCLK  input  1  system clock, rising edge active.
REQ-003 SHALL have iRST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have iValid  input  1  decode-stage instruction valid.
REQ-005 SHALL have iPC, iInstr  input  XLEN each  PC and encoding of the instruction in decode.
REQ-006 SHALL have iMisFetch, iIllegal, iEcall, iEbreak, iMisLoad, iMisStore  input  1 each  exception flags.
REQ-007 SHALL have iUret, iCsrOp  input  1 each  uret or CSR-instruction decoded.
REQ-008 SHALL have iRs1Val  input  XLEN  rs1 operand value.
REQ-009 SHALL have iCSROld  input  XLEN  current value of the addressed CSR.
REQ-010 SHALL have iUTVEC, iUEPC  input  XLEN each  current utvec and uepc.
REQ-011 SHALL have oCSRWrite  output  1  write enable to the CSR file.
REQ-012 SHALL have oUcause  output  XLEN  cause to the CSR file (0x0000000F marks a CSR instruction write).
REQ-013 SHALL have oPC, oInstr  output  XLEN each  captured PC and instruction for uepc/utval.
REQ-014 SHALL have oWriteData  output  XLEN  CSR write data.
REQ-015 SHALL have oRedirect  output  1  PC redirect request.
REQ-016 SHALL have oTargetPC  output  XLEN  redirect target.
REQ-017 SHALL have oStall, oFlush  output  1 each  pipeline hold and squash.
REQ-018 SHALL have oTrapCount  output  XLEN  number of traps taken.

Function
REQ-019 SHALL implement FSM states IDLE, TRAP_SAVE, TRAP_JUMP, RET_JUMP and CSR_WR.
REQ-020 SHALL accept an event only in IDLE with iValid=1, capturing iPC, iInstr, iRs1Val, iCSROld and iInstr[14:12] into registers on that edge.
REQ-021 SHALL, on accept, go to TRAP_SAVE if any exception flag is set, else RET_JUMP if iUret, else CSR_WR if iCsrOp, else remain in IDLE.
REQ-022 SHALL give exceptions priority over uret and CSR when flags are simultaneous.
REQ-023 SHALL select the cause by priority iMisFetch=0 > iIllegal=2 > iEbreak=3 > iEcall=8 > iMisStore=6 > iMisLoad=4, latched at accept.
REQ-024 SHALL, in TRAP_SAVE, assert oCSRWrite=1 with oUcause=latched cause and oPC/oInstr=captured values for exactly one cycle, then go to TRAP_JUMP.
REQ-025 SHALL, in TRAP_JUMP, assert oRedirect=1 and oFlush=1 with oTargetPC=iUTVEC with bits [1:0] cleared, increment oTrapCount (modulo 2^XLEN, wrap from all-ones to 0), then go to IDLE.
REQ-026 SHALL, in RET_JUMP, assert oRedirect=1 and oFlush=1 with oTargetPC=iUEPC, without a CSR write, then go to IDLE.
REQ-027 SHALL, in CSR_WR, assert oCSRWrite=1 with oUcause=0x0000000F for one cycle, then go to IDLE.
REQ-028 SHALL compute oWriteData from the latched funct3: 001 gives rs1; 010 gives old|rs1; 011 gives old&~rs1; 101/110/111 are the same operations with zero-extended zimm=instr[19:15] in place of rs1.
REQ-029 SHALL suppress oCSRWrite in CSR_WR when funct3 is 010/011/110/111 and instr[19:15]=0.
REQ-030 SHALL assert oStall whenever state is not IDLE; inputs arriving while busy are ignored.
REQ-031 SHALL drive oCSRWrite, oRedirect and oFlush to 0, and oWriteData, oTargetPC and oUcause to 0, in any state where they are not specified.
REQ-032 SHALL give every event a latency of 2 cycles from accept edge to redirect for traps, and 1 cycle from accept to CSR write.

Reset
REQ-033 SHALL, on iRST, go to IDLE immediately, including mid-sequence, abandoning any pending write or redirect.
REQ-034 SHALL, on iRST, clear all captured registers and oTrapCount to 0, so that every output reads 0.

Structure
REQ-035 SHALL take state encodings, cause codes (0, 2, 3, 4, 6, 8, 0x0F) and funct3 codes from the shared parameters include used by the CSR file.
REQ-036 SHALL place the oWriteData calculation in one combinational sub-module, csr_alu.

Verification
REQ-037 SHALL test illegal instruction: iIllegal=1, iPC=0x00400010, iInstr=0xFFFFFFFF -> next cycle oCSRWrite=1, oUcause=2, oPC=0x00400010; then oRedirect=1 with oTargetPC=iUTVEC&~3; oTrapCount=1.
REQ-038 SHALL test priority: iMisFetch=1 and iEcall=1 together -> oUcause=0; iEcall=1 with iUret=1 -> oUcause=8, no RET_JUMP.
REQ-039 SHALL test csrrs: iCSROld=0x0000F0F0, iRs1Val=0x0000000F, rs1 field non-zero -> oWriteData=0x0000F0FF with oUcause=0xF; with rs1 field=0 -> oCSRWrite stays 0.
REQ-040 SHALL test csrrci: iCSROld=0x1F, zimm=0x03 -> oWriteData=0x1C.
REQ-041 SHALL test uret: iUret=1, iUEPC=0x00400020 -> 1 cycle later oRedirect=1, oTargetPC=0x00400020, oCSRWrite=0 throughout.
REQ-042 SHALL test reset in TRAP_SAVE: iRST asserted -> state IDLE, all outputs 0, oTrapCount=0; events during oStall=1 are ignored.
